// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a byte register file and a local read/write port
module i2c_target_regfile #(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int NUM_REGS = 16,
    parameter int FILT_LEN = 3,
    localparam int PW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic [PW-1:0] loc_addr_i,
    input  logic          loc_we_i,
    input  logic [7:0]    loc_wdata_i,
    output logic [7:0]    loc_rdata_o,
    output logic          i2c_wr_o,
    output logic [PW-1:0] i2c_wr_idx_o,
    output logic          busy_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, AA_S, AA_E, RX_PTR, RX_DATA, AD_S, AD_E,
        TX, TX_REL, TX_MACK, TX_LOAD, WAIT_P
    } state_t;

    state_t state, state_n;
    logic [FILT_LEN:0] scl_c, sda_c;
    logic scl_f, sda_f, scl_q, sda_q;
    logic rise, fall, start, stop;
    logic [7:0] regs [NUM_REGS];
    logic [PW-1:0] ptr;
    logic [6:0] sh;
    logic [7:0] byte_in;
    logic [2:0] cnt;
    logic rw;
    logic oe_n, shift, tick, ld_ptr, wr, inc, load, bset, bclr;

    assign rise = scl_f & ~scl_q;
    assign fall = ~scl_f & scl_q;
    assign start = scl_f & scl_q & sda_q & ~sda_f;
    assign stop = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_in = {sh, sda_f};
    assign loc_rdata_o = regs[loc_addr_i];

    // Two sync stages feed a window of FILT_LEN samples; a level is accepted only when the window agrees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_c <= '1;
            sda_c <= '1;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_c <= {scl_c[FILT_LEN-1:0], scl_i};
            sda_c <= {sda_c[FILT_LEN-1:0], sda_i};
            scl_f <= (&scl_c[FILT_LEN:1]) ? 1'b1 : (~|scl_c[FILT_LEN:1]) ? 1'b0 : scl_f;
            sda_f <= (&sda_c[FILT_LEN:1]) ? 1'b1 : (~|sda_c[FILT_LEN:1]) ? 1'b0 : sda_f;
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // Protocol state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    // Bus events drive the next state and datapath strobes; STOP/START override bit handling
    always_comb begin
        state_n = state;
        oe_n = sda_oe_o;
        shift = 1'b0;
        tick = 1'b0;
        ld_ptr = 1'b0;
        wr = 1'b0;
        inc = 1'b0;
        load = 1'b0;
        bset = 1'b0;
        bclr = 1'b0;
        if (stop) begin
            state_n = IDLE;
            oe_n = 1'b0;
            bclr = 1'b1;
        end else if (start) begin
            state_n = ADDR;
            oe_n = 1'b0;
        end else begin
            case (state)
                ADDR: if (rise) begin
                    shift = 1'b1;
                    tick = 1'b1;
                    if (cnt == 3'd7) begin
                        state_n = (byte_in[7:1] == I2C_ADDR) ? AA_S : IDLE;
                        bset = (byte_in[7:1] == I2C_ADDR);
                        bclr = (byte_in[7:1] != I2C_ADDR);
                    end
                end
                AA_S: if (fall) begin
                    state_n = AA_E;
                    oe_n = 1'b1;
                end
                AA_E: if (fall) begin
                    state_n = rw ? TX : RX_PTR;
                    load = rw;
                    oe_n = rw & ~regs[ptr][7];
                end
                RX_PTR: if (rise) begin
                    shift = 1'b1;
                    tick = 1'b1;
                    if (cnt == 3'd7) begin
                        ld_ptr = 1'b1;
                        state_n = AD_S;
                    end
                end
                RX_DATA: if (rise) begin
                    shift = 1'b1;
                    tick = 1'b1;
                    if (cnt == 3'd7) begin
                        wr = 1'b1;
                        inc = 1'b1;
                        state_n = AD_S;
                    end
                end
                AD_S: if (fall) begin
                    state_n = AD_E;
                    oe_n = 1'b1;
                end
                AD_E: if (fall) begin
                    state_n = RX_DATA;
                    oe_n = 1'b0;
                end
                TX: if (rise) begin
                    tick = 1'b1;
                    if (cnt == 3'd7) state_n = TX_REL;
                end else if (fall) begin
                    shift = 1'b1;
                    oe_n = ~sh[6];
                end
                TX_REL: if (fall) begin
                    state_n = TX_MACK;
                    oe_n = 1'b0;
                    inc = 1'b1;
                end
                TX_MACK: if (rise) begin
                    state_n = sda_f ? WAIT_P : TX_LOAD;
                    bclr = sda_f;
                end
                TX_LOAD: if (fall) begin
                    state_n = TX;
                    load = 1'b1;
                    oe_n = ~regs[ptr][7];
                end
                default: ;
            endcase
        end
    end

    // Datapath: SDA drive, shift register, pointer, register file and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe_o <= 1'b0;
            i2c_wr_o <= 1'b0;
            i2c_wr_idx_o <= '0;
            busy_o <= 1'b0;
            ptr <= '0;
            sh <= '0;
            cnt <= '0;
            rw <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sda_oe_o <= oe_n;
            i2c_wr_o <= wr;
            if (wr) i2c_wr_idx_o <= ptr;
            if (bset) busy_o <= 1'b1;
            else if (bclr) busy_o <= 1'b0;
            if (start) cnt <= '0;
            else if (tick) cnt <= cnt + 1'b1;
            if (load) sh <= regs[ptr][6:0];
            else if (shift) sh <= byte_in[6:0];
            if (bset) rw <= byte_in[0];
            if (ld_ptr) ptr <= byte_in[PW-1:0];
            else if (inc) ptr <= ptr + 1'b1;
            if (loc_we_i) regs[loc_addr_i] <= loc_wdata_i;
            if (wr) regs[ptr] <= byte_in;
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master transactions against the target register file
module tb_i2c_target_regfile;
    localparam int Q = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_oe;
    logic [3:0] loc_addr = '0;
    logic loc_we = 1'b0;
    logic [7:0] loc_wdata = '0;
    logic [7:0] loc_rdata;
    logic i2c_wr;
    logic [3:0] wr_idx;
    logic busy;
    logic sda;
    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    logic [3:0] wr_log [64];

    assign sda = m_sda & ~sda_oe;

    i2c_target_regfile dut (
        .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda), .sda_oe_o(sda_oe),
        .loc_addr_i(loc_addr), .loc_we_i(loc_we), .loc_wdata_i(loc_wdata),
        .loc_rdata_o(loc_rdata), .i2c_wr_o(i2c_wr), .i2c_wr_idx_o(wr_idx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Bus activity log: SDA drive cycles, busy cycles and every I2C write index
    always @(posedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (i2c_wr) begin
            wr_log[wr_cnt[5:0]] = wr_idx;
            wr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input string tag, input logic [3:0] a, input logic [7:0] e);
        loc_addr = a;
        #1;
        chk(tag, {24'd0, loc_rdata}, {24'd0, e});
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_addr = a;
        loc_wdata = d;
        loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
    endtask

    task automatic i_start;
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i_stop;
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic g);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        if (g) begin
            m_sda = ~b;
            tick(1);
            m_sda = b;
            tick(Q - 1);
        end else tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        b = sda;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic mack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(~mack, 1'b0);
    endtask

    initial begin
        logic a, b;
        logic [7:0] d0, d1, d2;
        int oe0, b0, w0;
        tick(3);
        chk("rst_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", i2c_wr, 0);
        reg_is("rst_reg0", 0, 8'h00);
        rst_n = 1'b1;
        tick(5);

        i_start;
        wr_byte(8'hA0, 8'h00, a); chk("t1_ack_addr", a, 1);
        chk("t1_busy", busy, 1);
        wr_byte(8'h03, 8'h00, a); chk("t1_ack_ptr", a, 1);
        wr_byte(8'hA5, 8'h00, a); chk("t1_ack_d0", a, 1);
        wr_byte(8'h5A, 8'h00, a); chk("t1_ack_d1", a, 1);
        i_stop;
        tick(2);
        chk("t1_busy_end", busy, 0);
        reg_is("t1_reg3", 3, 8'hA5);
        reg_is("t1_reg4", 4, 8'h5A);
        chk("t1_wr_cnt", wr_cnt, 2);
        chk("t1_idx0", {28'd0, wr_log[0]}, 3);
        chk("t1_idx1", {28'd0, wr_log[1]}, 4);

        loc_write(2, 8'h77);
        i_start;
        wr_byte(8'hA0, 8'h00, a); chk("t2_ack_addr", a, 1);
        wr_byte(8'h02, 8'h00, a); chk("t2_ack_ptr", a, 1);
        i_start;
        wr_byte(8'hA1, 8'h00, a); chk("t2_ack_raddr", a, 1);
        rd_byte(d0, 1'b1);
        rd_byte(d1, 1'b1);
        rd_byte(d2, 1'b0);
        chk("t2_rd0", {24'd0, d0}, 8'h77);
        chk("t2_rd1", {24'd0, d1}, 8'hA5);
        chk("t2_rd2", {24'd0, d2}, 8'h5A);
        chk("t2_oe_nack", sda_oe, 0);
        i_stop;
        tick(2);
        chk("t2_busy_end", busy, 0);

        oe0 = oe_cnt;
        b0 = busy_cnt;
        w0 = wr_cnt;
        i_start;
        wr_byte(8'hA2, 8'h00, a); chk("t3_nack_addr", a, 0);
        wr_byte(8'h03, 8'h00, a);
        wr_byte(8'hFF, 8'h00, a);
        i_stop;
        tick(2);
        chk("t3_oe_never", oe_cnt - oe0, 0);
        chk("t3_busy_never", busy_cnt - b0, 0);
        chk("t3_no_wr", wr_cnt - w0, 0);
        reg_is("t3_reg3", 3, 8'hA5);

        i_start;
        wr_byte(8'hA0, 8'h00, a); chk("t4_ack_addr", a, 1);
        wr_byte(8'h0F, 8'h00, a); chk("t4_ack_ptr", a, 1);
        wr_byte(8'h11, 8'h00, a); chk("t4_ack_d0", a, 1);
        wr_byte(8'h22, 8'h00, a); chk("t4_ack_d1", a, 1);
        i_stop;
        tick(2);
        reg_is("t4_reg15", 15, 8'h11);
        reg_is("t4_reg0", 0, 8'h22);
        chk("t4_idx15", {28'd0, wr_log[2]}, 15);
        chk("t4_idx0", {28'd0, wr_log[3]}, 0);

        i_start;
        wr_byte(8'hA0, 8'h00, a); chk("t5_ack_addr", a, 1);
        wr_byte(8'h08, 8'h18, a); chk("t5_ack_ptr_glitch", a, 1);
        wr_byte(8'h99, 8'h00, a); chk("t5_ack_data", a, 1);
        i_stop;
        tick(2);
        reg_is("t5_reg8", 8, 8'h99);
        chk("t5_idx8", {28'd0, wr_log[4]}, 8);
        chk("t5_wr_cnt", wr_cnt, 5);

        i_start;
        wr_byte(8'hA1, 8'h00, a); chk("t6_ack_raddr", a, 1);
        recv_bit(b);
        recv_bit(b);
        chk("t6_bit", b, 0);
        chk("t6_oe_pre", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_oe_rst", sda_oe, 0);
        chk("t6_busy_rst", busy, 0);
        reg_is("t6_reg8_clr", 8, 8'h00);
        reg_is("t6_reg3_clr", 3, 8'h00);
        tick(2);
        rst_n = 1'b1;
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);

        i_start;
        wr_byte(8'hA0, 8'h00, a); chk("t7_ack_addr", a, 1);
        wr_byte(8'h06, 8'h00, a); chk("t7_ack_ptr", a, 1);
        wr_byte(8'h3C, 8'h00, a); chk("t7_ack_data", a, 1);
        i_start;
        wr_byte(8'hA0, 8'h00, a);
        wr_byte(8'h06, 8'h00, a);
        i_start;
        wr_byte(8'hA1, 8'h00, a); chk("t7_ack_raddr", a, 1);
        rd_byte(d0, 1'b0);
        i_stop;
        tick(2);
        chk("t7_rd", {24'd0, d0}, 8'h3C);
        reg_is("t7_reg6", 6, 8'h3C);
        chk("t7_idx6", {28'd0, wr_log[5]}, 6);
        chk("t7_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
